// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired T0..T5 control sequencer driving the datapath strobes.
// Optional ILLEGAL_TRAP_EN: illegal opcodes halt with Illegal=1 instead of running as nop.
module control_sequencer #(
  parameter int NREGS = 16,
  parameter int OPW   = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [31:0]      IR,
  input  logic             Mem_ready,
  input  logic             Stop,
  output logic             PCout,
  output logic             Zlowout,
  output logic             MDRout,
  output logic             MARin,
  output logic             Zin,
  output logic             PCin,
  output logic             MDRin,
  output logic             IRin,
  output logic             Yin,
  output logic             IncPC,
  output logic             Read,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic [OPW-1:0]   ALU_op,
  output logic             Run,
  output logic             Illegal,
  output logic [2:0]       Step
);

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    T5   = 3'd5,
    HALT = 3'd7
  } step_t;

  step_t          state;
  logic           first_t1;
  logic [3:0]     ra_q;
  logic [3:0]     rc_q;
  logic [OPW-1:0] op_q;

  logic [OPW-1:0] opcode;
  logic           is_alu;
  logic           is_nop;
  logic           is_halt;
  logic           unused_ir;

  assign opcode    = IR[31 -: OPW];
  assign is_alu    = (opcode >= OPW'(3)) && (opcode <= OPW'(11));
  assign is_nop    = (opcode == OPW'(26));
  assign is_halt   = (opcode == OPW'(27));
  assign unused_ir = ^IR[14:0];

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign Illegal = illegal_q;
`else
  assign Illegal = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= T0;
      first_t1 <= 1'b0;
      ra_q     <= '0;
      rc_q     <= '0;
      op_q     <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state)
        T0: begin
          state    <= T1;
          first_t1 <= 1'b1;
        end
        T1: begin
          first_t1 <= 1'b0;
          if (Mem_ready) state <= T2;
        end
        T2: state <= T3;
        T3: begin
          if (is_alu) begin
            // Latch the fields T4/T5 need so later IR changes cannot disturb them.
            ra_q  <= IR[26:23];
            rc_q  <= IR[18:15];
            op_q  <= opcode;
            state <= T4;
          end else if (is_halt) begin
            state <= HALT;
          end else if (is_nop) begin
            state <= Stop ? HALT : T0;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            state     <= HALT;
            illegal_q <= 1'b1;
`else
            state <= Stop ? HALT : T0;
`endif
          end
        end
        T4:      state <= T5;
        T5:      state <= Stop ? HALT : T0;
        HALT:    state <= HALT;
        default: state <= T0;
      endcase
    end
  end

  assign Step = state;
  assign Run  = Reset || (state != HALT);

  // Strobes are a pure decode of the step; Reset forces them quiet during the reset cycle.
  always_comb begin
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    MARin   = 1'b0;
    Zin     = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Rin     = '0;
    Rout    = '0;
    ALU_op  = '0;
    if (!Reset) begin
      case (state)
        T0: begin
          PCout = 1'b1;
          MARin = 1'b1;
          IncPC = 1'b1;
          Zin   = 1'b1;
        end
        T1: begin
          Read    = 1'b1;
          MDRin   = 1'b1;
          Zlowout = first_t1;
          PCin    = first_t1;
        end
        T2: begin
          MDRout = 1'b1;
          IRin   = 1'b1;
        end
        T3: begin
          if (is_alu) begin
            Rout = NREGS'(1) << IR[22:19];
            Yin  = 1'b1;
          end
        end
        T4: begin
          Rout   = NREGS'(1) << rc_q;
          Zin    = 1'b1;
          ALU_op = op_q;
        end
        T5: begin
          Zlowout = 1'b1;
          Rin     = NREGS'(1) << ra_q;
        end
        default: ;
      endcase
    end
  end

endmodule
